// File: rtl/board_pkg.sv
// Shared types and helpers for the read side of the board register bank.
package board_pkg;

   // Frame sequencing states of the row streamer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } reader_state_t;

   // Row index width; never narrower than one bit so a 1-row port stays legal.
   function automatic int idx_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/board_snapshot.sv
// Frozen copy of the board, loaded on request and read out one row at a time.
module board_snapshot
   import board_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic [WIDTH*HEIGHT-1:0]    board,
   input  logic [idx_w(HEIGHT)-1:0]   row_sel,
   output logic [WIDTH-1:0]           row
);

   localparam int IW = idx_w(HEIGHT);

   logic [WIDTH*HEIGHT-1:0] snap_d;
   logic [WIDTH*HEIGHT-1:0] snap_q;

   // Next snapshot: capture the whole live board on load, otherwise hold.
   always_comb begin
      snap_d = snap_q;
      if (load) begin
         snap_d = board;
      end
   end

   // Snapshot register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         snap_q <= '0;
      end else begin
         snap_q <= snap_d;
      end
   end

   // Row select; indices past the last row read as zero rather than out of range.
   always_comb begin
      row = '0;
      for (int r = 0; r < HEIGHT; r++) begin
         if (row_sel == IW'(r)) begin
            row = snap_q[r*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/board_reader.sv
// Captures a consistent board snapshot on start and streams it out one row
// per valid/ready transfer, finishing each frame with a one-cycle done pulse.
module board_reader
   import board_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH*HEIGHT-1:0]    board,
   input  logic                       start,
   output logic                       busy,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic [WIDTH-1:0]           row_data,
   output logic [idx_w(HEIGHT)-1:0]   row_idx,
   output logic                       row_last,
   output logic                       done
);

   localparam int             IW       = idx_w(HEIGHT);
   localparam logic [IW-1:0]  LAST_IDX = IW'(HEIGHT - 1);

   reader_state_t  state_d, state_q;
   logic [IW-1:0]  cnt_d, cnt_q;
   logic           busy_d, busy_q;
   logic           valid_d, valid_q;
   logic           last_d, last_q;
   logic           done_d, done_q;
   logic           load_snap;

   // Snapshot is only loaded when a start is accepted from IDLE.
   assign load_snap = (state_q == IDLE) && start;

   board_snapshot #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_snapshot (
      .clk     (clk),
      .reset   (reset),
      .load    (load_snap),
      .board   (board),
      .row_sel (cnt_q),
      .row     (row_data)
   );

   // Next-state, counter and registered-output decode for the frame FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEND;
               cnt_d   = '0;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               last_d  = (LAST_IDX == '0);
            end
         end
         SEND: begin
            if (valid_q && row_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d  = cnt_q + IW'(1);
                  last_d = ((cnt_q + IW'(1)) == LAST_IDX);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // Frame FSM registers; reset wins over any start in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign row_valid = valid_q;
   assign row_idx   = cnt_q;
   assign row_last  = last_q;
   assign done      = done_q;

endmodule
